// File: rtl/io_bus_pkg.sv
// Shared I/O address map: address field positions, device slots
// and sequencer state encoding for the I/O bus controller.
package io_bus_pkg;

   localparam int ADDR_W   = 7;
   localparam int DEV_LSB  = 4;
   localparam int DEV_W    = 3;
   localparam int REG_LSB  = 0;
   localparam int REG_W    = 4;
   localparam int NUM_SLOT = 8;
   localparam int NUM_DEVS = 4;

   localparam logic [DEV_W-1:0] DEV_TIMER = 3'd0;
   localparam logic [DEV_W-1:0] DEV_GPIO  = 3'd1;
   localparam logic [DEV_W-1:0] DEV_UART  = 3'd2;
   localparam logic [DEV_W-1:0] DEV_SPI   = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } bus_state_t;

   function automatic logic [NUM_SLOT-1:0] dev_onehot(
      input logic [DEV_W-1:0] dev
   );
      return NUM_SLOT'(1) << dev;
   endfunction

   // Slots at or above NUM_DEVS are reserved and answer with an error.
   function automatic logic dev_reserved(
      input logic [DEV_W-1:0] dev
   );
      return dev >= DEV_W'(NUM_DEVS);
   endfunction

endpackage

// File: rtl/io_bus_timeout.sv
// Wait counter for ACCESS: counts enabled cycles, flags expiry on the
// LIMIT-th one. Ports: clk, rst_n, clear, enable -> expired.
module io_bus_timeout #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Combinational so the FSM leaves ACCESS after exactly LIMIT cycles.
   assign expired = enable && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/io_bus_controller.sv
// Sequencer from the CPU load/store port onto the I/O peripheral bus:
// address decode, one transaction per request, ready handshake, data
// steering and bus-error reporting for reserved slots.
// Ports: Clock/Reset_n; CPU side IoReq/IoWrite/IoAddr/IoWrData ->
// IoRdData/IoDone/IoErr/IoBusy; device side DevSel/RegAddr/DevWrEn/
// DevRdEn/DevWrData, DevRdData/DevReady.
// Option: define IO_BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module io_bus_controller
   import io_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DATA_W         = 32
) (
   input  logic                         Clock,
   input  logic                         Reset_n,
   input  logic                         IoReq,
   input  logic                         IoWrite,
   input  logic [ADDR_W-1:0]            IoAddr,
   input  logic [DATA_W-1:0]            IoWrData,
   output logic [DATA_W-1:0]            IoRdData,
   output logic                         IoDone,
   output logic                         IoErr,
   output logic                         IoBusy,
   output logic [NUM_SLOT-1:0]          DevSel,
   output logic [REG_W-1:0]             RegAddr,
   output logic                         DevWrEn,
   output logic                         DevRdEn,
   output logic [DATA_W-1:0]            DevWrData,
   input  logic [NUM_SLOT*DATA_W-1:0]   DevRdData,
   input  logic [NUM_SLOT-1:0]          DevReady
);

   bus_state_t state, state_nx;

   logic              wr_q;
   logic [DEV_W-1:0]  dev_q;
   logic [REG_W-1:0]  reg_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_q;
   logic              err_q;

   logic [DEV_W-1:0]  req_dev;
   logic              req_rsvd;
   logic              in_access;
   logic              ready_sel;
   logic              expired;
   logic [DATA_W-1:0] rd_slice;

   assign req_dev   = IoAddr[DEV_LSB +: DEV_W];
   assign req_rsvd  = dev_reserved(req_dev);
   assign in_access = (state == ST_ACCESS);
   assign ready_sel = DevReady[dev_q];

   always_comb begin
      rd_slice = '0;
      for (int i = 0; i < NUM_SLOT; i++) begin
         if (dev_q == DEV_W'(i)) begin
            rd_slice = DevRdData[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef IO_BUS_TIMEOUT_EN
   io_bus_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (Clock),
      .rst_n   (Reset_n),
      .clear   (!in_access),
      .enable  (in_access),
      .expired (expired)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign expired = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (IoReq) begin
               state_nx = req_rsvd ? ST_DONE : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (ready_sel || expired) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_q    <= 1'b0;
         dev_q   <= '0;
         reg_q   <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == ST_IDLE && IoReq) begin
            wr_q    <= IoWrite;
            dev_q   <= req_dev;
            reg_q   <= IoAddr[REG_LSB +: REG_W];
            wdata_q <= IoWrData;
            rd_q    <= '0;
            err_q   <= req_rsvd;
         end else if (in_access) begin
            // Ready beats a same-cycle timeout.
            if (ready_sel) begin
               rd_q  <= wr_q ? '0 : rd_slice;
               err_q <= 1'b0;
            end else if (expired) begin
               rd_q  <= '0;
               err_q <= 1'b1;
            end
         end
      end
   end

   assign DevSel    = in_access ? dev_onehot(dev_q) : '0;
   assign DevWrEn   = in_access && wr_q;
   assign DevRdEn   = in_access && !wr_q;
   assign RegAddr   = reg_q;
   assign DevWrData = wdata_q;

   assign IoDone   = (state == ST_DONE);
   assign IoErr    = IoDone && err_q;
   assign IoRdData = IoDone ? rd_q : '0;
   assign IoBusy   = (state != ST_IDLE);

endmodule
